aud_player: RTL and testbench



---
 rtl/aud_pkg.sv | 18 +
 rtl/aud_sync_edge.sv | 40 ++++
 rtl/aud_player.sv | 137 +++++++++++++
 tb/tb_aud_player.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// aud_pkg: shared definitions for the I2S playback path.
//   aud_state_t     : serializer states (S_IDLE / S_WAIT / S_SEND / S_DONE)
//   AUD_DATA_W      : default sample width
//   AUD_SYNC_STAGES : default flop count of each pin synchronizer
`timescale 1ns/1ps
package aud_pkg;

  localparam int AUD_DATA_W      = 16;
  localparam int AUD_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } aud_state_t;

endpackage

// File: rtl/aud_sync_edge.sv
// aud_sync_edge: brings an asynchronous codec clock pin into i_clk and
// reports its level plus single-cycle rise/fall pulses.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_pin          : asynchronous input pin
//   o_level        : synchronized level
//   o_rise/o_fall  : one-cycle edge pulses, STAGES+1 cycles after the pin
`timescale 1ns/1ps
module aud_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  assign o_level = sync_q[STAGES-1];

  // Edge pulses are registered so that every consumer sees them exactly
  // STAGES+1 cycles after the pin moves, free of combinational glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_pin};
      hist_q <= sync_q[STAGES-1];
      o_rise <= sync_q[STAGES-1] & ~hist_q;
      o_fall <= ~sync_q[STAGES-1] & hist_q;
    end
  end

endmodule

// File: rtl/aud_player.sv
// aud_player: serializes one DSP sample per stereo frame onto the WM8731
// DAC data pin in I2S format (mono duplicated on both channels, MSB first,
// one BCLK delay after each DACLRCK edge).
//   i_clk, i_rst_n : system clock (>= 8x BCLK), async active-low reset
//   i_en           : playback enable (level)
//   i_mute         : latch zero instead of i_dac_data
//   i_bclk         : codec bit clock (async)
//   i_daclrck      : codec DAC LR clock (async), low = left
//   i_dac_data     : signed sample from the DSP stage
//   i_atten        : arithmetic right-shift amount (only with
//                    AUD_PLAYER_ATTEN_EN defined)
//   o_aud_dacdat   : serial DAC data
//   o_sample_req   : one-cycle pulse when a new sample is latched
//   o_busy         : high whenever the serializer is not idle
`timescale 1ns/1ps
module aud_player
  import aud_pkg::*;
#(
  parameter int DATA_W      = AUD_DATA_W,
  parameter int SYNC_STAGES = AUD_SYNC_STAGES
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_mute,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_dac_data,
`ifdef AUD_PLAYER_ATTEN_EN
  input  logic [3:0]        i_atten,
`endif
  output logic              o_aud_dacdat,
  output logic              o_sample_req,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  aud_state_t        state;
  logic [DATA_W-1:0] sample_r;
  logic [DATA_W-1:0] shift_r;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] new_sample;

  logic bclk_lvl, bclk_rise, bclk_fall;
  logic lrck_lvl, lrck_rise, lrck_fall;
  logic unused_sync;

  aud_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_bclk),
    .o_level (bclk_lvl),
    .o_rise  (bclk_rise),
    .o_fall  (bclk_fall)
  );

  aud_sync_edge #(.STAGES(SYNC_STAGES)) u_lrck_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_daclrck),
    .o_level (lrck_lvl),
    .o_rise  (lrck_rise),
    .o_fall  (lrck_fall)
  );

  // Only the edges that move the serializer are consumed.
  assign unused_sync = ^{bclk_lvl, bclk_rise, lrck_lvl};

  // Value captured at the start of a frame. Mute overrides attenuation.
  always_comb begin
    new_sample = '0;
    if (!i_mute) begin
`ifdef AUD_PLAYER_ATTEN_EN
      new_sample = DATA_W'($signed(i_dac_data) >>> i_atten);
`else
      new_sample = i_dac_data;
`endif
    end
  end

  assign o_busy = (state != S_IDLE);

  // Priority: disable, then LR edge, then bit clock. An LR edge that
  // coincides with a BCLK fall swallows that fall, which produces the
  // one-BCLK I2S delay in S_WAIT. A rise from idle is ignored so that
  // playback always begins on a left channel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      sample_r     <= '0;
      shift_r      <= '0;
      bit_cnt      <= '0;
      o_aud_dacdat <= 1'b0;
      o_sample_req <= 1'b0;
    end else begin
      o_sample_req <= 1'b0;
      if (!i_en) begin
        state        <= S_IDLE;
        o_aud_dacdat <= 1'b0;
      end else if (lrck_fall) begin
        sample_r     <= new_sample;
        shift_r      <= new_sample;
        o_sample_req <= 1'b1;
        bit_cnt      <= '0;
        o_aud_dacdat <= 1'b0;
        state        <= S_WAIT;
      end else if (lrck_rise && state != S_IDLE) begin
        shift_r      <= sample_r;
        bit_cnt      <= '0;
        o_aud_dacdat <= 1'b0;
        state        <= S_WAIT;
      end else if (bclk_fall) begin
        case (state)
          S_WAIT: begin
            o_aud_dacdat <= shift_r[DATA_W-1];
            shift_r      <= {shift_r[DATA_W-2:0], 1'b0};
            bit_cnt      <= CNT_W'(1);
            state        <= S_SEND;
          end
          S_SEND: begin
            if (bit_cnt == CNT_W'(DATA_W)) begin
              o_aud_dacdat <= 1'b0;
              state        <= S_DONE;
            end else begin
              o_aud_dacdat <= shift_r[DATA_W-1];
              shift_r      <= {shift_r[DATA_W-2:0], 1'b0};
              bit_cnt      <= bit_cnt + CNT_W'(1);
            end
          end
          default: o_aud_dacdat <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_player.sv
`timescale 1ns/1ps
module tb_aud_player;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic        i_mute;
  logic        i_bclk;
  logic        i_daclrck;
  logic [15:0] i_dac_data;
  logic [3:0]  atten_v;
  logic        o_aud_dacdat;
  logic        o_sample_req;
  logic        o_busy;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  int lat_l = 0;

  aud_player dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_mute       (i_mute),
    .i_bclk       (i_bclk),
    .i_daclrck    (i_daclrck),
    .i_dac_data   (i_dac_data),
`ifdef AUD_PLAYER_ATTEN_EN
    .i_atten      (atten_v),
`endif
    .o_aud_dacdat (o_aud_dacdat),
    .o_sample_req (o_sample_req),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_sample_req === 1'b1) req_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] data;
    logic        mute;
    logic [3:0]  atten;
    int          n;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  // Reference: the word the codec would reconstruct from one channel of
  // n BCLKs. Sample = (mute ? 0 : data / 2^atten, floored); a channel with
  // fewer than 17 BCLKs only has room for its top n-1 bits.
  function automatic logic [15:0] model(input logic [15:0] d, input logic m,
                                        input logic [3:0] a, input int n);
    int v;
    logic [15:0] w;
    int drop;
    v = m ? 0 : int'($signed(d));
    v = v >>> a;
    w = v[15:0];
    if (n < 17) begin
      drop = 17 - n;
      w = (w >> drop) << drop;
    end
    return w;
  endfunction

  // One channel: n BCLK periods, LR pin set on the first falling edge.
  // Codec-side view: the data pin and busy are sampled just before each rise.
  task automatic chan(input logic lr, input int n,
                      output logic [63:0] b, output logic [63:0] bz);
    b  = '0;
    bz = '0;
    for (int k = 0; k < n; k++) begin
      i_bclk = 1'b0;
      if (k == 0) i_daclrck = lr;
      if (k == 1 && lr == 1'b0) lat_l = 0;
      for (int c = 1; c <= 8; c++) begin
        @(posedge i_clk); #1;
        if (k == 1 && lr == 1'b0 && lat_l == 0 && o_aud_dacdat === 1'b1) lat_l = c;
      end
      #1;
      b[k]  = o_aud_dacdat;
      bz[k] = o_busy;
      i_bclk = 1'b1;
      clk_n(8);
    end
  endtask

  task automatic chk_chan(input string nm, input logic [63:0] b, input logic [63:0] bz,
                          input int n, input logic [15:0] exp);
    logic [15:0] w;
    logic [63:0] tail;
    w = '0;
    tail = '0;
    for (int k = 0; k < n; k++) begin
      if (k >= 1 && k <= 16) w[16-k] = b[k];
      else tail[k] = b[k];
    end
    chk({nm, "_word"}, {48'd0, w}, {48'd0, exp});
    chk({nm, "_tail"}, tail, 64'd0);
    chk({nm, "_busy"}, bz, (64'd1 << n) - 64'd1);
  endtask

  task automatic frame(input logic [15:0] d, input logic m, input int n,
                       input logic [15:0] exp, input string nm);
    logic [63:0] b, bz;
    int r0;
    i_dac_data = d;
    i_mute = m;
    r0 = req_cnt;
    chan(1'b0, n, b, bz);
    chk_chan({nm, "_L"}, b, bz, n, exp);
    chan(1'b1, n, b, bz);
    chk_chan({nm, "_R"}, b, bz, n, exp);
    chk({nm, "_req"}, 64'(req_cnt - r0), 64'd1);
  endtask

  initial begin
    vec_t vt[$];
    logic [63:0] b, bz;
    logic [15:0] d;
    logic m;
    int n;

    vt.push_back('{16'hA5C3, 1'b0, 4'd0, 32, 16'hA5C3});
    vt.push_back('{16'h7FFF, 1'b1, 4'd0, 32, 16'h0000});
    vt.push_back('{16'hA5C3, 1'b0, 4'd0, 16, 16'hA5C2});
    vt.push_back('{16'h1234, 1'b0, 4'd0, 17, 16'h1234});
    vt.push_back('{16'h8001, 1'b0, 4'd0, 20, 16'h8001});
    vt.push_back('{16'hFFFF, 1'b0, 4'd0, 24, 16'hFFFF});
`ifdef AUD_PLAYER_ATTEN_EN
    vt.push_back('{16'h8000, 1'b0, 4'd4,  32, 16'hF800});
    vt.push_back('{16'h0100, 1'b0, 4'd4,  32, 16'h0010});
    vt.push_back('{16'h8000, 1'b1, 4'd4,  32, 16'h0000});
    vt.push_back('{16'h7FFF, 1'b0, 4'd15, 32, 16'h0000});
    vt.push_back('{16'h8000, 1'b0, 4'd15, 32, 16'hFFFF});
`endif

    // Reset with DACLRCK high: the rise seen after release must not start play.
    i_rst_n = 1'b0; i_en = 1'b1; i_mute = 1'b0; i_bclk = 1'b1;
    i_daclrck = 1'b1; i_dac_data = '0; atten_v = '0;
    clk_n(3);
    chk("rst_dacdat", {63'd0, o_aud_dacdat}, 64'd0);
    chk("rst_req",    {63'd0, o_sample_req}, 64'd0);
    chk("rst_busy",   {63'd0, o_busy},       64'd0);
    i_rst_n = 1'b1;
    clk_n(20);
    chk("idle_busy", {63'd0, o_busy}, 64'd0);

    // Directed table.
    foreach (vt[i]) begin
      atten_v = vt[i].atten;
      frame(vt[i].data, vt[i].mute, vt[i].n, vt[i].exp, $sformatf("vec%0d", i));
    end
    atten_v = '0;

    // Pin-to-data latency: MSB appears 4 cycles after the second BCLK fall.
    frame(16'hFFFF, 1'b0, 32, 16'hFFFF, "lat");
    chk("lat_cycles", 64'(lat_l), 64'd4);

    // Disable mid-word, then re-enable during the right channel.
    i_dac_data = 16'hFFFF; i_mute = 1'b0;
    chan(1'b0, 6, b, bz);
    i_bclk = 1'b0;
    clk_n(6);
    chk("dis_pre_dat", {63'd0, o_aud_dacdat}, 64'd1);
    i_en = 1'b0;
    @(posedge i_clk); #1;
    chk("dis_dat",  {63'd0, o_aud_dacdat}, 64'd0);
    chk("dis_busy", {63'd0, o_busy},       64'd0);
    clk_n(1);
    i_bclk = 1'b1;
    clk_n(8);
    chan(1'b0, 25, b, bz);
    chan(1'b1, 8, b, bz);
    chk("dis_r_dat",  b,  64'd0);
    chk("dis_r_busy", bz, 64'd0);
    i_en = 1'b1;
    chan(1'b1, 24, b, bz);
    chk("reen_r_dat",  b,  64'd0);
    chk("reen_r_busy", bz, 64'd0);
    frame(16'hFFFF, 1'b0, 32, 16'hFFFF, "reen");

    // Asynchronous reset during S_SEND, released while DACLRCK is high.
    chan(1'b0, 6, b, bz);
    chk("ars_pre_dat", {63'd0, o_aud_dacdat}, 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("ars_dat",  {63'd0, o_aud_dacdat}, 64'd0);
    chk("ars_busy", {63'd0, o_busy},       64'd0);
    chk("ars_req",  {63'd0, o_sample_req}, 64'd0);
    chan(1'b0, 26, b, bz);
    chan(1'b1, 4, b, bz);
    i_rst_n = 1'b1;
    chan(1'b1, 28, b, bz);
    chk("ars_r_dat",  b,  64'd0);
    chk("ars_r_busy", bz, 64'd0);
    frame(16'h5A3C, 1'b0, 32, 16'h5A3C, "ars_restart");

    // Randomized frames against the reference model.
    for (int i = 0; i < 14; i++) begin
      d = 16'($urandom);
      m = ($urandom_range(3) == 0);
      n = $urandom_range(33, 16);
`ifdef AUD_PLAYER_ATTEN_EN
      atten_v = 4'($urandom_range(15));
`endif
      frame(d, m, n, model(d, m, atten_v, n), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
